// File: rtl/vn_byte_extractor.sv
// vn_byte_extractor
// Post-processing stage for the ring-oscillator TRNG: divides down the
// sample rate, removes bias with a von Neumann pair extractor, packs the
// surviving bits into words behind a valid/ready port, and keeps saturating
// raw ones/total counters used to tune the bias VDAC.
module vn_byte_extractor #(
    parameter int BITWIDTH  = 8,
    parameter int DIV_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 raw_bit,
    input  logic [DIV_WIDTH-1:0] sample_div,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [BITWIDTH-1:0]  out_data,
    output logic                 overrun,
    input  logic                 clr_stats,
    output logic [CNT_WIDTH-1:0] raw_ones,
    output logic [CNT_WIDTH-1:0] raw_total
);

    localparam int BCW = (BITWIDTH > 2) ? $clog2(BITWIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(BITWIDTH - 1);

    typedef enum logic {
        FIRST  = 1'b0,
        SECOND = 1'b1
    } pair_state_e;

    // The partial word never holds more than BITWIDTH-1 bits: the bit that
    // completes a word goes straight into out_data together with these.
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    pair_state_e          state_q, state_d;
    logic                 first_q, first_d;
    logic [BITWIDTH-2:0]  shreg_q, shreg_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [BITWIDTH-1:0]  out_data_q, out_data_d;
    logic                 overrun_q, overrun_d;
    logic [CNT_WIDTH-1:0] raw_ones_q, raw_ones_d;
    logic [CNT_WIDTH-1:0] raw_total_q, raw_total_d;

    logic                 strobe;
    logic                 word_done;
    logic [BITWIDTH-1:0]  word;

    // Sample-rate divider: >= comparison recovers when sample_div is lowered
    // below the current count; held at zero while disabled.
    always_comb begin
        strobe    = en && (div_cnt_q >= sample_div);
        div_cnt_d = div_cnt_q;
        if (!en || strobe) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
        end
    end

    // Von Neumann pair FSM and word packing; disabling drops any half pair
    // and any partial word so the next word is built only from fresh bits.
    always_comb begin
        state_d   = state_q;
        first_d   = first_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        word_done = 1'b0;
        word      = {shreg_q, first_q};
        if (!en) begin
            state_d   = FIRST;
            shreg_d   = '0;
            bit_cnt_d = '0;
        end else if (strobe) begin
            if (state_q == FIRST) begin
                first_d = raw_bit;
                state_d = SECOND;
            end else begin
                state_d = FIRST;
                if (first_q != raw_bit) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        word_done = 1'b1;
                        bit_cnt_d = '0;
                        shreg_d   = '0;
                    end else begin
                        shreg_d   = {shreg_q[BITWIDTH-3:0], first_q};
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
        end
    end

    // Output word register: a completed word is accepted if the slot is
    // empty or being drained this cycle, otherwise it is dropped and the
    // sticky overrun flag is raised.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        overrun_d   = overrun_q;
        if (word_done) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                out_data_d  = word;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Saturating raw statistics; a clear wins over a same-cycle sample.
    always_comb begin
        raw_ones_d  = raw_ones_q;
        raw_total_d = raw_total_q;
        if (clr_stats) begin
            raw_ones_d  = '0;
            raw_total_d = '0;
        end else if (strobe) begin
            if (!(&raw_total_q)) begin
                raw_total_d = raw_total_q + CNT_WIDTH'(1);
            end
            if (raw_bit && !(&raw_ones_q)) begin
                raw_ones_d = raw_ones_q + CNT_WIDTH'(1);
            end
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q   <= '0;
            state_q     <= FIRST;
            first_q     <= 1'b0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overrun_q   <= 1'b0;
            raw_ones_q  <= '0;
            raw_total_q <= '0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            state_q     <= state_d;
            first_q     <= first_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overrun_q   <= overrun_d;
            raw_ones_q  <= raw_ones_d;
            raw_total_q <= raw_total_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign overrun   = overrun_q;
    assign raw_ones  = raw_ones_q;
    assign raw_total = raw_total_q;

endmodule

// File: tb/tb_vn_byte_extractor.sv
// Directed testbench for vn_byte_extractor with a word scoreboard.
module tb_vn_byte_extractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        raw_bit;
    logic [7:0]  sample_div;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        overrun;
    logic        clr_stats;
    logic [15:0] raw_ones;
    logic [15:0] raw_total;

    logic        s_out_valid;
    logic [7:0]  s_out_data;
    logic        s_overrun;
    logic [3:0]  s_raw_ones;
    logic [3:0]  s_raw_total;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_word;
    logic        seen_valid;

    vn_byte_extractor #(.BITWIDTH(8), .DIV_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .en(en), .raw_bit(raw_bit), .sample_div(sample_div),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .overrun(overrun), .clr_stats(clr_stats), .raw_ones(raw_ones),
        .raw_total(raw_total)
    );

    // Narrow-counter instance sharing all inputs, used for saturation checks.
    vn_byte_extractor #(.BITWIDTH(8), .DIV_WIDTH(8), .CNT_WIDTH(4)) dut_small (
        .clk(clk), .rst(rst), .en(en), .raw_bit(raw_bit), .sample_div(sample_div),
        .out_ready(out_ready), .out_valid(s_out_valid), .out_data(s_out_data),
        .overrun(s_overrun), .clr_stats(clr_stats), .raw_ones(s_raw_ones),
        .raw_total(s_raw_total)
    );

    always #5 clk = ~clk;

    // One clock: inputs set beforehand are captured, outputs settle by +1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one raw sample per cycle (div=0) for a von Neumann word: each
    // extracted bit b is sent as the pair {b, ~b}, MSB first.
    task automatic applyStimulus(input logic [7:0] bits);
        for (int i = 7; i >= 0; i--) begin
            raw_bit = bits[i];
            tick();
            raw_bit = ~bits[i];
            tick();
        end
    endtask

    // Scoreboard: every transfer (valid && ready at the coming edge) pops
    // the next expected word.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_word", {24'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                exp_word = exp_q.pop_front();
                checkOutput("word", {24'd0, out_data}, {24'd0, exp_word});
            end
        end
    end

    initial begin
        logic [15:0] pat1;
        rst = 1'b1; en = 1'b0; raw_bit = 1'b0; sample_div = 8'd0;
        out_ready = 1'b0; clr_stats = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_data", {24'd0, out_data}, 32'd0);
        checkOutput("reset_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("reset_total", {16'd0, raw_total}, 32'd0);

        // Pattern 1: pairs 10,01,10,10,01,01,10,01 -> 8'hB2
        pat1 = 16'b1001_1010_0101_1001;
        out_ready = 1'b1;
        en = 1'b1;
        exp_q.push_back(8'hB2);
        for (int i = 15; i >= 0; i--) begin
            raw_bit = pat1[i];
            tick();
        end
        checkOutput("p1_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("p1_data", {24'd0, out_data}, 32'hB2);
        en = 1'b0;
        tick();
        checkOutput("p1_valid_one_cycle", {31'd0, out_valid}, 32'd0);
        checkOutput("p1_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("p1_ones", {16'd0, raw_ones}, 32'd8);
        checkOutput("p1_total", {16'd0, raw_total}, 32'd16);

        // Constant 1s: all pairs discarded, counters track every sample.
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        en = 1'b1;
        raw_bit = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        en = 1'b0;
        checkOutput("ones_no_valid", {31'd0, seen_valid}, 32'd0);
        checkOutput("ones_raw_ones", {16'd0, raw_ones}, 32'd1000);
        checkOutput("ones_raw_total", {16'd0, raw_total}, 32'd1000);
        tick();

        // Backpressure: second word dropped, first held, overrun sticky.
        out_ready = 1'b0;
        en = 1'b1;
        exp_q.push_back(8'hB2);
        applyStimulus(8'hB2);
        applyStimulus(8'hB2);
        checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_data", {24'd0, out_data}, 32'hB2);
        checkOutput("bp_overrun", {31'd0, overrun}, 32'd1);
        en = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("bp_drained", {31'd0, out_valid}, 32'd0);
        checkOutput("bp_overrun_sticky", {31'd0, overrun}, 32'd1);
        tick();

        // Divider=3: samples at en-cycles 3,7,11,... alternate 1,0 -> 8'hFF.
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        sample_div = 8'd3;
        out_ready = 1'b1;
        en = 1'b1;
        exp_q.push_back(8'hFF);
        for (int c = 0; c < 64; c++) begin
            raw_bit = ((c % 8) < 4);
            tick();
            if (c == 62) checkOutput("div_valid_early", {31'd0, out_valid}, 32'd0);
        end
        checkOutput("div_valid_at_64", {31'd0, out_valid}, 32'd1);
        checkOutput("div_data", {24'd0, out_data}, 32'hFF);
        en = 1'b0;
        tick();
        checkOutput("div_total", {16'd0, raw_total}, 32'd16);
        checkOutput("div_ones", {16'd0, raw_ones}, 32'd8);
        sample_div = 8'd0;

        // Saturation of the 4-bit counters and clear overriding a sample.
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        en = 1'b1;
        raw_bit = 1'b1;
        repeat (20) tick();
        checkOutput("sat_ones", {28'd0, s_raw_ones}, 32'd15);
        checkOutput("sat_total", {28'd0, s_raw_total}, 32'd15);
        checkOutput("wide_total", {16'd0, raw_total}, 32'd20);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        en = 1'b0;
        checkOutput("clr_ones", {28'd0, s_raw_ones}, 32'd0);
        checkOutput("clr_total", {28'd0, s_raw_total}, 32'd0);
        tick();

        // Reset after 5 extracted bits: next word built from fresh bits only.
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            raw_bit = 1'b1;
            tick();
            raw_bit = 1'b0;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_mid_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("rst_mid_ones", {16'd0, raw_ones}, 32'd0);
        exp_q.push_back(8'h2D);
        applyStimulus(8'h2D);
        checkOutput("rst_fresh_data", {24'd0, out_data}, 32'h2D);
        en = 1'b0;
        tick();

        // en=0 after 5 bits: partial word discarded, held word retained.
        out_ready = 1'b0;
        en = 1'b1;
        exp_q.push_back(8'h5A);
        applyStimulus(8'h5A);
        for (int i = 0; i < 5; i++) begin
            raw_bit = 1'b1;
            tick();
            raw_bit = 1'b0;
            tick();
        end
        en = 1'b0;
        tick();
        checkOutput("en0_held_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("en0_held_data", {24'd0, out_data}, 32'h5A);
        out_ready = 1'b1;
        en = 1'b1;
        exp_q.push_back(8'hC3);
        applyStimulus(8'hC3);
        checkOutput("en0_fresh_data", {24'd0, out_data}, 32'hC3);
        checkOutput("en0_overrun", {31'd0, overrun}, 32'd0);
        en = 1'b0;
        tick();
        tick();

        checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
